// File: rtl/bcd_alu_pkg.sv
// bcd_alu_pkg: shared types and constants for the digit-serial BCD ALU.
//   bcd_digit_t   - one packed BCD digit
//   state_t       - controller states (FIX is always declared, reachable
//                   only when BCD_ALU_SIGN_MAG_EN is defined)
//   BCD_MAX_DIGIT - largest legal digit, also the 9's complement base
//   BCD_ADJ       - decimal adjust added when a binary digit sum exceeds 9
//   digit_bad()   - flags a nibble that is not a legal BCD digit
package bcd_alu_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;
  localparam bcd_digit_t BCD_ADJ       = 4'd6;

  function automatic logic digit_bad(input bcd_digit_t d);
    return (d > BCD_MAX_DIGIT);
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// bcd_digit_add: combinational single-digit BCD adder with decimal adjust.
// Ports:
//   a, b  - input BCD digits (b may already be 9's complemented)
//   cin   - carry in
//   sum   - adjusted BCD sum digit
//   cout  - decimal carry out
module bcd_digit_add
  import bcd_alu_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       cin,
  output bcd_digit_t sum,
  output logic       cout
);

  logic [4:0] bin_sum;
  logic [4:0] adj_sum;

  // Binary add, then add 6 when the result leaves the decimal range.
  always_comb begin
    bin_sum = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    adj_sum = bin_sum + {1'b0, BCD_ADJ};
    if (bin_sum > {1'b0, BCD_MAX_DIGIT}) begin
      sum  = adj_sum[3:0];
      cout = 1'b1;
    end else begin
      sum  = bin_sum[3:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_alu.sv
// bcd_serial_alu: digit-serial packed-BCD add/subtract, LSD first, one digit
// per clock through a single shared bcd_digit_add.
// Ports:
//   clk, rst_n   - rising-edge clock, asynchronous active-low reset
//   start, sub   - operation request (sampled in IDLE), 0 = a+b, 1 = a-b
//   a, b         - packed BCD operands, digit 0 in [3:0]
//   ready / busy - IDLE / (RUN, FIX, DONE) status, mutually exclusive
//   done         - one-cycle pulse when result/carry/err/neg are updated
//   result       - packed BCD result, held until the next done
//   carry        - add: decimal carry out; sub: 1 = no borrow
//   err          - an operand digit was > 9
//   neg          - sign flag, only ever set with BCD_ALU_SIGN_MAG_EN
// Build option: define BCD_ALU_SIGN_MAG_EN to return negative differences as
// magnitude plus neg = 1 (extra FIX pass) instead of 10's complement.
module bcd_serial_alu
  import bcd_alu_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   result,
  output logic                  carry,
  output logic                  err,
  output logic                  neg
);

  localparam int W     = 4 * DIGITS;
  localparam int CNT_W = $clog2(DIGITS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

`ifdef BCD_ALU_SIGN_MAG_EN
  localparam logic SIGN_MAG = 1'b1;
`else
  localparam logic SIGN_MAG = 1'b0;
`endif

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d, sh_q, sh_d, result_q, result_d;
  logic             sub_q, sub_d, carry_q, carry_d, err_q, err_d;
  logic             neg_pend_q, neg_pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cout_q, cout_d, err_out_q, err_out_d, neg_q, neg_d;
  logic             done_q, done_d;

  bcd_digit_t       add_a, add_b, add_sum;
  logic             add_cout;
  logic             any_bad;
  logic [W+3:0]     sh_ext, a_ext, b_ext;

  bcd_digit_add u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Operand legality check on the raw inputs sampled at start.
  always_comb begin
    any_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      any_bad = any_bad | digit_bad(a[4*i +: 4]) | digit_bad(b[4*i +: 4]);
    end
  end

  // Adder operand mux: FIX computes 0 - raw using the 9's complement of the
  // raw digit that sits at the bottom of the shift register.
  always_comb begin
    if (state_q == FIX) begin
      add_a = 4'd0;
      add_b = BCD_MAX_DIGIT - sh_q[3:0];
    end else begin
      add_a = a_q[3:0];
      add_b = sub_q ? (BCD_MAX_DIGIT - b_q[3:0]) : b_q[3:0];
    end
  end

  // Shifted views: new sum digit enters at the MSD end, operands drop LSD.
  always_comb begin
    sh_ext = {add_sum, sh_q} >> 4'd4;
    a_ext  = {4'd0, a_q} >> 4'd4;
    b_ext  = {4'd0, b_q} >> 4'd4;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sub_d      = sub_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    sh_d       = sh_q;
    neg_pend_d = neg_pend_q;
    result_d   = result_q;
    cout_d     = cout_q;
    err_out_d  = err_out_q;
    neg_d      = neg_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          a_d        = a;
          b_d        = b;
          sub_d      = sub;
          carry_d    = sub;
          cnt_d      = '0;
          err_d      = any_bad;
          sh_d       = '0;
          neg_pend_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (err_q) begin
          state_d = DONE;
        end else begin
          carry_d = add_cout;
          sh_d    = sh_ext[W-1:0];
          a_d     = a_ext[W-1:0];
          b_d     = b_ext[W-1:0];
          if (cnt_q == LAST_CNT) begin
            if (SIGN_MAG && sub_q && !add_cout) begin
              state_d    = FIX;
              cnt_d      = '0;
              carry_d    = 1'b1;
              neg_pend_d = 1'b1;
            end else begin
              state_d = DONE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      FIX: begin
        carry_d = add_cout;
        sh_d    = sh_ext[W-1:0];
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (err_q) begin
          result_d  = '0;
          cout_d    = 1'b0;
          err_out_d = 1'b1;
          neg_d     = 1'b0;
        end else begin
          result_d  = sh_q;
          cout_d    = carry_q & ~neg_pend_q;
          err_out_d = 1'b0;
          neg_d     = neg_pend_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, working and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sub_q      <= 1'b0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      sh_q       <= '0;
      neg_pend_q <= 1'b0;
      result_q   <= '0;
      cout_q     <= 1'b0;
      err_out_q  <= 1'b0;
      neg_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sub_q      <= sub_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      sh_q       <= sh_d;
      neg_pend_q <= neg_pend_d;
      result_q   <= result_d;
      cout_q     <= cout_d;
      err_out_q  <= err_out_d;
      neg_q      <= neg_d;
      done_q     <= done_d;
    end
  end

  assign ready  = (state_q == IDLE);
  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign carry  = cout_q;
  assign err    = err_out_q;
  assign neg    = neg_q;

endmodule

// File: tb/tb_bcd_serial_alu.sv
// tb_bcd_serial_alu: directed self-checking bench for bcd_serial_alu with
// DIGITS = 2. Expected values are hand-computed BCD results.
module tb_bcd_serial_alu;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       sub;
  logic [7:0] a;
  logic [7:0] b;
  logic       ready, busy, done, carry, err, neg;
  logic [7:0] result;

  int vectors;
  int miscompares;

  bcd_serial_alu #(.DIGITS(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .result (result),
    .carry  (carry),
    .err    (err),
    .neg    (neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation and check latency, ready timing and outputs.
  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                        input logic ts, input int exp_edges, input logic [7:0] exp_res,
                        input logic exp_c, input logic exp_err, input logic exp_neg);
    int n;
    int rdy_low;
    int excl_bad;
    @(negedge clk);
    a = ta; b = tb_; sub = ts; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rdy_low  = (ready == 1'b0) ? 1 : 0;
    excl_bad = (ready === busy) ? 1 : 0;
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (ready === busy) excl_bad++;
      if (done === 1'b1) break;
      if (ready == 1'b0) rdy_low++;
    end
    check({tag, "_edges"}, n, exp_edges);
    check({tag, "_ready_low"}, rdy_low, exp_edges);
    check({tag, "_excl"}, excl_bad, 0);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_carry"}, carry, exp_c);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_neg"}, neg, exp_neg);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_hold"}, result, exp_res);
  endtask

  initial begin
    int dones;
    int n;
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = 8'h00; b = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_outs", {result, carry, err, neg}, 11'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add_47_38", 8'h47, 8'h38, 1'b0, 3, 8'h85, 1'b0, 1'b0, 1'b0);
    run_op("add_99_01", 8'h99, 8'h01, 1'b0, 3, 8'h00, 1'b1, 1'b0, 1'b0);
    run_op("sub_52_17", 8'h52, 8'h17, 1'b1, 3, 8'h35, 1'b1, 1'b0, 1'b0);
`ifdef BCD_ALU_SIGN_MAG_EN
    run_op("sub_03_05", 8'h03, 8'h05, 1'b1, 5, 8'h02, 1'b0, 1'b0, 1'b1);
`else
    run_op("sub_03_05", 8'h03, 8'h05, 1'b1, 3, 8'h98, 1'b0, 1'b0, 1'b0);
`endif
    run_op("err_1a", 8'h1A, 8'h00, 1'b0, 2, 8'h00, 1'b0, 1'b1, 1'b0);

    // Second start pulse during RUN must be ignored.
    @(negedge clk);
    a = 8'h47; b = 8'h38; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    check("busy_start_dones", dones, 1);
    check("busy_start_result", result, 8'h85);

    // Reset mid-RUN aborts with no done.
    @(negedge clk);
    a = 8'h99; b = 8'h99; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_ready", ready, 1'b1);
    check("abort_outs", {busy, done, result, carry, err, neg}, 13'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    check("abort_no_done", dones, 0);
    check("abort_result", result, 8'h00);

    // Held start: 0x12+0x34, then immediate re-trigger after DONE.
    @(negedge clk);
    a = 8'h12; b = 8'h34; sub = 1'b0; start = 1'b1;
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (done === 1'b1) break;
    end
    check("held_edges", n, 4);
    check("held_result", result, 8'h46);
    check("held_carry", carry, 1'b0);
    @(posedge clk); #1;
    check("held_retrigger_busy", busy, 1'b1);
    start = 1'b0;
    n = 0;
    while (n < 20 && done !== 1'b1) begin
      @(posedge clk); #1;
      n++;
    end
    check("retrigger_done_seen", done, 1'b1);
    check("retrigger_result", result, 8'h46);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
